// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one fixed-latency, single-ported memory between I-cache
// and D-cache miss traffic. One access in flight at a time; a one-cycle done
// pulse (with read data on reads) goes back to the port that owned the access.
// Optional feature: define MEM_ARB_RR_EN to alternate grants on simultaneous
// requests (last_owner register); otherwise D always beats I.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner,
    output logic          busy
);

    // A one-cycle memory still needs a 1-bit counter that simply stays at zero.
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_lat;
    logic          last_cycle;
    logic          arb_open;
    logic          grant_d;
    logic          grant_i;

    // The completing cycle re-arbitrates exactly like IDLE, so there is no bubble.
    assign last_cycle = (state != IDLE) && (cnt == '0);
    assign arb_open   = (state == IDLE) || last_cycle;

`ifdef MEM_ARB_RR_EN
    logic last_owner;   // 0 = I, 1 = D

    // On a tie, grant the port that did not own the previous access.
    always_comb begin
        grant_d = d_req && (!i_req || !last_owner);
        grant_i = i_req && !grant_d;
    end

    // Remember who was granted last; starts as I so the first tie goes to D.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= 1'b0;
        end else if (arb_open && (grant_d || grant_i)) begin
            last_owner <= grant_d;
        end
    end
`else
    // Fixed priority: D wins whenever both request.
    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

    // Access sequencer: grant, latch the request, strobe memory once, count latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_lat    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            if (arb_open) begin
                if (grant_d) begin
                    state     <= BUSY_D;
                    cnt       <= CNT_INIT;
                    wr_lat    <= d_wr;
                    mem_en    <= 1'b1;
                    mem_wr    <= d_wr;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else if (grant_i) begin
                    state     <= BUSY_I;
                    cnt       <= CNT_INIT;
                    wr_lat    <= 1'b0;
                    mem_en    <= 1'b1;
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Completion and data returns decode registered state only.
    assign i_done  = (state == BUSY_I) && (cnt == '0);
    assign d_done  = (state == BUSY_D) && (cnt == '0);
    assign i_rdata = i_done ? mem_rdata : '0;
    assign d_rdata = (d_done && !wr_lat) ? mem_rdata : '0;
    assign owner   = {state == BUSY_D, state == BUSY_I};
    assign busy    = (state != IDLE);

endmodule
